// File: rtl/bin_bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one shift per two clocks.
// Optional BCD_AUTO_CONVERT_EN: also launch in IDLE whenever bin_in differs
// from the last converted value.
// Ports: i_clk, rst_n (async, active-low), start, bin_in[WIDTH],
//        busy, done (1-cycle pulse), bcd_out[4*DIGITS] (ones in [3:0]).
module bin_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  i_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADD   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic bit range_ok();
      longint p;
      longint m;
      p = 1;
      for (int i = 0; i < DIGITS; i++) p = p * 10;
      m = (longint'(1) << WIDTH) - 1;
      return p > m;
   endfunction

   localparam bit RANGE_OK = range_ok();

   generate
      if (!RANGE_OK) begin : g_bad_cfg
         $error("bin_bcd_seq: DIGITS too small for WIDTH");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] bin_q;
   logic [BW-1:0]    scratch;
   logic [BW-1:0]    adj;
   logic [CW-1:0]    cnt;
   logic             launch;

`ifdef BCD_AUTO_CONVERT_EN
   logic [WIDTH-1:0] last_bin;

   assign launch = start | (bin_in != last_bin);

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n)
         last_bin <= '0;
      else if (state == S_IDLE && launch)
         last_bin <= bin_in;
   end
`else
   assign launch = start;
`endif

   // Per-digit +3 correction; no carry crosses a digit boundary.
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         bin_q   <= '0;
         scratch <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (launch) begin
                  bin_q   <= bin_in;
                  scratch <= '0;
                  cnt     <= CW'(WIDTH);
                  busy    <= 1'b1;
                  state   <= S_ADD;
               end
            end
            S_ADD: begin
               scratch <= adj;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               {scratch, bin_q} <= {scratch, bin_q} << 1;
               cnt   <= cnt - CW'(1);
               state <= (cnt == CW'(1)) ? S_DONE : S_ADD;
            end
            S_DONE: begin
               bcd_out <= scratch;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Randomized self-checking bench for bin_bcd_seq (WIDTH=8, DIGITS=3).
// Reference digits come from plain decimal arithmetic on the input value.
module tb_bin_bcd_seq;

   localparam int W = 8;
   localparam int D = 3;
   localparam int LAT = 2 * W + 1;

   logic           i_clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   bin_in;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd_out;

   int n_chk;
   int n_pass;

   bin_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .i_clk   (i_clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [4*D-1:0] ref_bcd(input int v);
      logic [4*D-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic launch(input int v);
      @(negedge i_clk);
      bin_in = W'(v);
      start  = 1'b1;
      @(posedge i_clk);
      #1;
      start = 1'b0;
   endtask

   // Call #1 after the launch edge; cyc = edges until done is seen.
   task automatic wait_done(input string tag, output int cyc,
                            output int bcyc);
      cyc  = 0;
      bcyc = busy ? 1 : 0;
      while (cyc < 60) begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (done) break;
         if (busy) bcyc++;
      end
      if (!done) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic conv(input string tag, input int v, input bit scramble);
      int cyc;
      int bcyc;
      launch(v);
      if (scramble) bin_in = W'($urandom);
      wait_done(tag, cyc, bcyc);
      chk({tag, "_lat"}, cyc, LAT);
      chk({tag, "_busy"}, bcyc, LAT);
      chk({tag, "_bcd"}, int'(bcd_out), int'(ref_bcd(v)));
      chk({tag, "_busy_off"}, int'(busy), 0);
      @(posedge i_clk);
      #1;
      chk({tag, "_pulse"}, int'(done), 0);
      chk({tag, "_hold"}, int'(bcd_out), int'(ref_bcd(v)));
   endtask

   task automatic count_done(input int n, output int nd);
      nd = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk);
         #1;
         if (done) nd++;
      end
   endtask

   initial begin
      int cyc;
      int bcyc;
      int nd;
      int v;
      int bad;
      n_chk  = 0;
      n_pass = 0;
      start  = 1'b0;
      bin_in = '0;
      rst_n  = 1'b1;

      #13;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bcd", int'(bcd_out), 0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      rst_n = 1'b1;
      count_done(5, nd);
      chk("idle_done", nd, 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_bcd", int'(bcd_out), 0);

`ifdef BCD_AUTO_CONVERT_EN
      @(negedge i_clk);
      bin_in = W'(143);
      @(posedge i_clk);
      #1;
      chk("auto_busy0", int'(busy), 1);
      wait_done("auto", cyc, bcyc);
      chk("auto_lat", cyc, LAT);
      chk("auto_bcd", int'(bcd_out), int'(ref_bcd(143)));
      count_done(40, nd);
      chk("auto_quiet", nd, 0);
      chk("auto_idle", int'(busy), 0);
      for (int t = 0; t < 8; t++) begin
         v = $urandom_range(255, 0);
         if (v == int'(bin_in)) v = (v + 1) % 256;
         @(negedge i_clk);
         bin_in = W'(v);
         @(posedge i_clk);
         #1;
         wait_done("auto_rnd", cyc, bcyc);
         chk("auto_rnd_lat", cyc, LAT);
         chk("auto_rnd_bcd", int'(bcd_out), int'(ref_bcd(v)));
         @(posedge i_clk);
         #1;
      end
`else
      conv("c255", 255, 1'b0);
      conv("c0", 0, 1'b0);
      conv("c100", 100, 1'b0);
      conv("c9", 9, 1'b0);
      conv("c199", 199, 1'b0);

      launch(200);
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      bin_in = W'(37);
      start  = 1'b1;
      @(posedge i_clk);
      #1;
      start = 1'b0;
      wait_done("drop", cyc, bcyc);
      chk("drop_bcd", int'(bcd_out), int'(ref_bcd(200)));
      count_done(30, nd);
      chk("drop_single", nd, 0);

      @(negedge i_clk);
      bin_in = W'(128);
      start  = 1'b1;
      @(posedge i_clk);
      #1;
      bin_in = W'(64);
      wait_done("b2b1", cyc, bcyc);
      chk("b2b1_lat", cyc, LAT);
      chk("b2b1_bcd", int'(bcd_out), int'(ref_bcd(128)));
      cyc = 0;
      bad = 0;
      while (cyc < 40) begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (done) break;
         if (bcd_out != ref_bcd(128)) bad++;
      end
      start = 1'b0;
      chk("b2b_gap", cyc, LAT + 1);
      chk("b2b_stable", bad, 0);
      chk("b2b2_bcd", int'(bcd_out), int'(ref_bcd(64)));
      count_done(25, nd);
      chk("b2b_stop", nd, 0);

      launch(173);
      repeat (7) @(posedge i_clk);
      @(negedge i_clk);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", int'(busy), 0);
      chk("mid_done", int'(done), 0);
      chk("mid_bcd", int'(bcd_out), 0);
      @(negedge i_clk);
      rst_n = 1'b1;
      count_done(25, nd);
      chk("mid_nodone", nd, 0);
      chk("mid_bcd2", int'(bcd_out), 0);
      conv("c173", 173, 1'b0);

      for (int t = 0; t < 20; t++) begin
         v = $urandom_range(255, 0);
         conv("rnd", v, 1'b1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bin_bcd_seq.md
Name: bin_bcd_seq

Overview:
- Sequential (shift-add-3 / double-dabble) binary-to-BCD converter.
- Consumes the 8-bit LFSR register value and feeds the digit mux / seven-segment path with hundreds/tens/ones nibbles.
- Uses one shift per two clocks instead of a combinational adder chain.
- Start/busy/done handshake; the output digits stay stable between conversions, so the display never shows intermediate values.

Parameters:
- WIDTH, 8, binary input width.
- DIGITS, 3, BCD digits produced. Requirement: 10^DIGITS > 2^WIDTH-1. Any other combination is unsupported, and an elaboration-time check flags it.

Ports:
- i_clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled on the i_clk rising edge.
- bin_in  input  WIDTH  binary value to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse: bcd_out has just updated.
- bcd_out  output  4*DIGITS  packed BCD. [3:0]=ones, [7:4]=tens, [11:8]=hundreds, and so on upward.

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, busy=0, done=0, bcd_out=0, internal shift/scratch/counter registers=0. Reset asserts immediately, regardless of the clock.
- State IDLE:
  - If start=1 at an edge: latch bin_in into the binary shift register, clear the BCD scratch register, load bit counter=WIDTH, go to ADD, busy<=1.
  - Otherwise stay in IDLE.
- State ADD (1 cycle): every scratch digit >=5 gets +3 (4-bit add, no carry into the next digit), then go to SHIFT.
- State SHIFT (1 cycle):
  - Shift {scratch, binary} left by 1 and decrement the counter.
  - If the counter reaches 0, go to DONE; otherwise go to ADD.
- State DONE (1 cycle):
  - bcd_out<=scratch, done<=1, busy<=0, go to IDLE.
  - done is cleared on the following edge unless the next conversion also finishes there (impossible for WIDTH>=1).
- Latency: start sampled at edge k. bcd_out and done are valid after edge k+2*WIDTH+1, which is 17 clocks for WIDTH=8. busy is high from after edge k until edge k+2*WIDTH+1.
- start while busy=1: ignored, no queuing. bin_in changes during a conversion do not affect the result.
- start high in the cycle done is high: the FSM is in IDLE, so the request is accepted and the next conversion begins. done still pulses exactly once.
- start held high continuously: conversions run back-to-back, one every 2*WIDTH+2 clocks.
- bcd_out changes only in DONE and holds its value otherwise.
- Reset mid-conversion: the conversion is abandoned, all outputs return to reset values, and no done pulse is issued.
- Input 0 gives all-zero digits. The maximum input 2^WIDTH-1 must convert exactly, e.g. 255 gives 0x255.

Optional Feature:
- Macro: BCD_AUTO_CONVERT_EN.
- Defined:
  - Adds a last_bin register, reset to 0, updated whenever a conversion is launched.
  - In IDLE, a conversion also launches when bin_in != last_bin, even with start=0.
  - Result: the display tracks the LFSR with no external start logic. Timing and handshake are identical otherwise.
- Not defined: conversions launch only on start, and last_bin does not exist.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> busy=0, done=0, bcd_out=0x000 immediately. With start=0 after release, the outputs stay there.
- Basic conversion: bin_in=255, start pulse at edge k -> busy high for 17 cycles, done one cycle after edge k+17, bcd_out=0x255. Repeat with 0 -> 0x000, 100 -> 0x100, 9 -> 0x009, 199 -> 0x199.
- Start while busy: start with 200, then start with bin_in=37 five cycles later -> single done, bcd_out=0x200, the 37 request is dropped.
- Back-to-back: start held high with bin_in=128 then 64 -> done pulses 18 clocks apart, bcd_out=0x128 then 0x064. bcd_out stays stable between pulses.
- Reset mid-op: start 173, pull rst_n low at cycle 8 -> outputs cleared, no done. Restart with 173 -> 0x173 after 17 cycles.
- BCD_AUTO_CONVERT_EN build: start tied 0, bin_in 0 -> 143 -> a conversion launches, done pulses, bcd_out=0x143. bin_in held at 143 -> no further conversions.
